control_sequencer: RTL and testbench

- Hardwired control unit that drives the register-select logic and the datapath strobes of the 32-bit CPU.
- Steps each instruction through fetch (T0-T2) and an opcode-specific execute sequence (T3-T7).
- Issues Gra/Grb/Grc/Rin/Rout/BAout to the select logic, plus the bus, register, ALU and memory controls.
- Outputs are a Moore decode of the state register and the latched IR opcode.

---
 rtl/control_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit CPU: fetch T0-T2, opcode-specific execute T3-T7.
// Strobes are a Moore decode of the state register and the IR opcode.
module control_sequencer #(
  parameter logic [4:0] ADD_OP        = 5'b00011,
  parameter bit         HALT_ON_UNDEF = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic [3:0]  state
);

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    C_RTYPE, C_ITYPE, C_LDI, C_LD, C_ST, C_BR, C_NOP, C_HALT, C_UNDEF
  } opcls_e;

  state_e            cur_state;
  state_e            nxt_state;
  opcls_e            opcls;
  logic [OP_W-1:0]   opcode;
  logic              unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign state     = cur_state;

  // Group opcodes by execute sequence
  always_comb begin
    opcls = C_UNDEF;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: opcls = C_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:      opcls = C_ITYPE;
      OP_LDI:                        opcls = C_LDI;
      OP_LD:                         opcls = C_LD;
      OP_ST:                         opcls = C_ST;
      OP_BR:                         opcls = C_BR;
      OP_NOP:                        opcls = C_NOP;
      OP_HALT:                       opcls = C_HALT;
      default:                       opcls = C_UNDEF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) cur_state <= S_RESET;
    else       cur_state <= nxt_state;
  end

  // Next state and strobe decode
  always_comb begin
    nxt_state = cur_state;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0; CONin = 1'b0; Gra = 1'b0; Grb = 1'b0;
    Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = ADD_OP;
    run    = 1'b1;

    case (cur_state)
      S_RESET: nxt_state = S_T0;
      S_T0: begin
        if (stop) begin
          nxt_state = S_HALT;
        end else begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
          nxt_state = S_T1;
        end
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        nxt_state = S_T2;
      end
      // Short opcodes retire here, so IR must already present the fetched word
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        case (opcls)
          C_NOP:   nxt_state = S_T0;
          C_HALT:  nxt_state = S_HALT;
          C_UNDEF: nxt_state = HALT_ON_UNDEF ? S_HALT : S_T0;
          default: nxt_state = S_T3;
        endcase
      end
      S_T3: begin
        nxt_state = S_T4;
        case (opcls)
          C_RTYPE, C_ITYPE:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_LDI, C_LD, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          C_BR:               begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          default:            nxt_state = S_T0;
        endcase
      end
      S_T4: begin
        nxt_state = S_T5;
        case (opcls)
          C_RTYPE:           begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          C_ITYPE:           begin Cout = 1'b1; Zin = 1'b1; alu_op = opcode; end
          C_LDI, C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
          C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
          default:           nxt_state = S_T0;
        endcase
      end
      S_T5: begin
        case (opcls)
          C_RTYPE, C_ITYPE, C_LDI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; nxt_state = S_T0;
          end
          C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; nxt_state = S_T6; end
          C_BR:       begin Cout = 1'b1; Zin = 1'b1; nxt_state = S_T6; end
          default:    nxt_state = S_T0;
        endcase
      end
      S_T6: begin
        case (opcls)
          C_LD:    begin Read = 1'b1; MDRin = 1'b1; nxt_state = S_T7; end
          C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; nxt_state = S_T7; end
          C_BR:    begin Zlowout = 1'b1; PCin = CON_FF; nxt_state = S_T0; end
          default: nxt_state = S_T0;
        endcase
      end
      S_T7: begin
        nxt_state = S_T0;
        case (opcls)
          C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_ST:    Write = 1'b1;
          default: ;
        endcase
      end
      S_HALT: begin
        run       = 1'b0;
        nxt_state = S_HALT;
      end
      default: nxt_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer, using a per-instruction
// expected-step list built from the opcode's documented micro-sequence.
module tb_control_sequencer;

  localparam logic [4:0] ADD = 5'b00011;

  localparam logic [19:0] M_PCOUT = 20'h80000, M_PCIN  = 20'h40000, M_INCPC = 20'h20000;
  localparam logic [19:0] M_MARIN = 20'h10000, M_MDRIN = 20'h08000, M_MDROUT = 20'h04000;
  localparam logic [19:0] M_READ  = 20'h02000, M_WRITE = 20'h01000, M_IRIN  = 20'h00800;
  localparam logic [19:0] M_YIN   = 20'h00400, M_ZIN   = 20'h00200, M_ZLOW  = 20'h00100;
  localparam logic [19:0] M_COUT  = 20'h00080, M_CONIN = 20'h00040, M_GRA   = 20'h00020;
  localparam logic [19:0] M_GRB   = 20'h00010, M_GRC   = 20'h00008, M_RIN   = 20'h00004;
  localparam logic [19:0] M_ROUT  = 20'h00002, M_BAOUT = 20'h00001;

  typedef struct {
    logic [3:0]  st;
    logic [19:0] m;
    logic [4:0]  alu;
    logic        run;
  } step_t;

  logic clock, reset, stop, CON_FF;
  logic [31:0] IR;

  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin, Zlowout;
  logic Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout, run;
  logic [4:0] alu_op;
  logic [3:0] state;

  logic u_PCout, u_PCin, u_IncPC, u_MARin, u_MDRin, u_MDRout, u_Read, u_Write, u_IRin;
  logic u_Yin, u_Zin, u_Zlowout, u_Cout, u_CONin, u_Gra, u_Grb, u_Grc, u_Rin, u_Rout;
  logic u_BAout, u_run;
  logic [4:0] u_alu_op;
  logic [3:0] u_state;

  logic [19:0] mask, u_mask;
  assign mask = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin,
                 Zlowout, Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout};
  assign u_mask = {u_PCout, u_PCin, u_IncPC, u_MARin, u_MDRin, u_MDRout, u_Read, u_Write,
                   u_IRin, u_Yin, u_Zin, u_Zlowout, u_Cout, u_CONin, u_Gra, u_Grb, u_Grc,
                   u_Rin, u_Rout, u_BAout};

  control_sequencer #(.ADD_OP(ADD), .HALT_ON_UNDEF(1'b0)) dut (
    .clock(clock), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Cout(Cout), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_op(alu_op), .run(run), .state(state)
  );

  control_sequencer #(.ADD_OP(ADD), .HALT_ON_UNDEF(1'b1)) dut_u (
    .clock(clock), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF),
    .PCout(u_PCout), .PCin(u_PCin), .IncPC(u_IncPC), .MARin(u_MARin), .MDRin(u_MDRin),
    .MDRout(u_MDRout), .Read(u_Read), .Write(u_Write), .IRin(u_IRin), .Yin(u_Yin),
    .Zin(u_Zin), .Zlowout(u_Zlowout), .Cout(u_Cout), .CONin(u_CONin), .Gra(u_Gra),
    .Grb(u_Grb), .Grc(u_Grc), .Rin(u_Rin), .Rout(u_Rout), .BAout(u_BAout),
    .alu_op(u_alu_op), .run(u_run), .state(u_state)
  );

  int total = 0;
  int bad   = 0;
  step_t exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, expv);
    end
  endtask

  function automatic void push(input int st, input logic [19:0] m, input logic [4:0] alu,
                               input logic r);
    step_t s;
    s.st = 4'(st); s.m = m; s.alu = alu; s.run = r;
    exp_q.push_back(s);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction on the HALT_ON_UNDEF=0 part
  function automatic void build_seq(input logic [4:0] op, input logic con, input logic stp);
    exp_q.delete();
    if (stp) begin
      push(1, 20'h0, ADD, 1'b1);
      return;
    end
    push(1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, ADD, 1'b1);
    push(2, M_ZLOW | M_PCIN | M_READ | M_MDRIN, ADD, 1'b1);
    push(3, M_MDROUT | M_IRIN, ADD, 1'b1);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        push(4, M_GRB | M_ROUT | M_YIN, ADD, 1'b1);
        push(5, M_GRC | M_ROUT | M_ZIN, op, 1'b1);
        push(6, M_ZLOW | M_GRA | M_RIN, ADD, 1'b1);
      end
      5'b01100, 5'b01101, 5'b01110: begin
        push(4, M_GRB | M_ROUT | M_YIN, ADD, 1'b1);
        push(5, M_COUT | M_ZIN, op, 1'b1);
        push(6, M_ZLOW | M_GRA | M_RIN, ADD, 1'b1);
      end
      5'b00001: begin
        push(4, M_GRB | M_BAOUT | M_YIN, ADD, 1'b1);
        push(5, M_COUT | M_ZIN, ADD, 1'b1);
        push(6, M_ZLOW | M_GRA | M_RIN, ADD, 1'b1);
      end
      5'b00000, 5'b00010: begin
        push(4, M_GRB | M_BAOUT | M_YIN, ADD, 1'b1);
        push(5, M_COUT | M_ZIN, ADD, 1'b1);
        push(6, M_ZLOW | M_MARIN, ADD, 1'b1);
        if (op == 5'b00000) begin
          push(7, M_READ | M_MDRIN, ADD, 1'b1);
          push(8, M_MDROUT | M_GRA | M_RIN, ADD, 1'b1);
        end else begin
          push(7, M_GRA | M_ROUT | M_MDRIN, ADD, 1'b1);
          push(8, M_WRITE, ADD, 1'b1);
        end
      end
      5'b10011: begin
        push(4, M_GRA | M_ROUT | M_CONIN, ADD, 1'b1);
        push(5, M_PCOUT | M_YIN, ADD, 1'b1);
        push(6, M_COUT | M_ZIN, ADD, 1'b1);
        push(7, M_ZLOW | (con ? M_PCIN : 20'h0), ADD, 1'b1);
      end
      default: ;
    endcase
  endfunction

  task automatic check_step(input step_t s);
    check_eq("state", 32'(state), 32'(s.st));
    check_eq("strobes", 32'(mask), 32'(s.m));
    check_eq("alu_op", 32'(alu_op), 32'(s.alu));
    check_eq("run", 32'(run), 32'(s.run));
    check_eq("u_state", 32'(u_state), 32'(s.st));
    check_eq("u_strobes", 32'(u_mask), 32'(s.m));
    check_eq("u_alu_op", 32'(u_alu_op), 32'(s.alu));
    check_eq("u_run", 32'(u_run), 32'(s.run));
    check_eq("bus_excl", 32'($countones({PCout, MDRout, Zlowout, Cout, Rout, BAout}) <= 1), 32'd1);
    check_eq("gr_excl", 32'($countones({Gra, Grb, Grc}) <= 1), 32'd1);
  endtask

  // Entered at a falling edge with both parts in T0
  task automatic do_instr(input logic [31:0] ir, input logic con, input logic stp);
    step_t s;
    IR = ir; CON_FF = con; stop = stp;
    build_seq(ir[31:27], con, stp);
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      #1 check_step(s);
      @(negedge clock);
    end
    stop = 1'b0;
  endtask

  task automatic do_reset();
    step_t s;
    reset = 1'b1;
    @(negedge clock);
    s.st = 4'd0; s.m = 20'h0; s.alu = ADD; s.run = 1'b1;
    #1 check_step(s);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_halted(input int cycles);
    step_t s;
    s.st = 4'd15; s.m = 20'h0; s.alu = ADD; s.run = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      #1 check_step(s);
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t observed=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  ops [12];
    logic [31:0] r;
    step_t s;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
            5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b10011, 5'b11001};
    reset = 1'b1; stop = 1'b0; IR = 32'h0; CON_FF = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    s.st = 4'd0; s.m = 20'h0; s.alu = ADD; s.run = 1'b1;
    #1 check_step(s);
    @(negedge clock);

    do_instr({5'b00011, 4'b0001, 4'b0000, 4'b0100, 15'b0}, 1'b0, 1'b0);
    do_instr({5'b00000, 4'd1, 4'd2, 19'h10}, 1'b0, 1'b0);
    do_instr({5'b00010, 4'd3, 4'd2, 19'h10}, 1'b0, 1'b0);
    do_instr({5'b00001, 4'd4, 4'd0, 19'h10}, 1'b0, 1'b0);
    do_instr({5'b10011, 4'd5, 4'd0, 19'h7}, 1'b0, 1'b0);
    do_instr({5'b10011, 4'd5, 4'd0, 19'h7}, 1'b1, 1'b0);
    do_instr({5'b11001, 27'h0}, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom();
      do_instr({ops[$urandom_range(0, 11)], r[26:0]}, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Halt opcode
    do_instr({5'b11010, 27'h0}, 1'b0, 1'b0);
    check_halted(20);
    do_reset();

    // Stop request during T0
    do_instr({5'b00011, 27'h0}, 1'b0, 1'b1);
    check_halted(20);
    do_reset();

    // Reset landing in ld T5
    IR = {5'b00000, 4'd1, 4'd2, 19'h10}; CON_FF = 1'b0;
    build_seq(5'b00000, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      s = exp_q.pop_front();
      #1 check_step(s);
      if (i == 5) reset = 1'b1;
      @(negedge clock);
    end
    s.st = 4'd0; s.m = 20'h0; s.alu = ADD; s.run = 1'b1;
    #1 check_step(s);
    reset = 1'b0;
    @(negedge clock);

    // Undefined opcode: plain part refetches, HALT_ON_UNDEF part halts
    do_instr({5'b11111, 27'h0}, 1'b0, 1'b0);
    #1;
    check_eq("undef_state", 32'(state), 32'd1);
    check_eq("undef_u_state", 32'(u_state), 32'd15);
    check_eq("undef_u_run", 32'(u_run), 32'd0);
    @(negedge clock);
    do_reset();
    do_instr({5'b00100, 27'h123}, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
